// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - CPU data-bus responder: null/UART/RAM decode with 8N1 TX queue and RX holding register

// TX byte queue: power-of-two ring buffer; a push while full is refused
module mem_bus_responder_txq #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;

    // fullness is judged on the pre-edge count, so a same-edge pop never rescues a push
    assign s_tready = (cnt != FULL_CNT);
    assign m_tvalid = (cnt != '0);
    assign m_tdata  = mem[rd_ptr];
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      cnt <= cnt + (AW+1)'(1);
            else if (pop && !push) cnt <= cnt - (AW+1)'(1);
        end
    end

    // queue storage, not reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_tdata;
    end
endmodule

// Responder top: address decode, RAM, status/flag logic, UART TX and RX
module mem_bus_responder #(
    parameter int CLK_DIV   = 16,
    parameter int TXQ_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mem_addr,
    input  logic       mem_wr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    input  logic       uart_rx,
    output logic       uart_tx
);
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // bus decode
    logic sel_ram;
    logic wr_ram;
    logic wr_txd;
    logic wr_ctl;

    assign sel_ram = (mem_addr >= 8'h20);
    assign wr_ram  = mem_wr && sel_ram;
    assign wr_txd  = mem_wr && (mem_addr == 8'h01);
    assign wr_ctl  = mem_wr && (mem_addr == 8'h02);

    // general RAM covering 20h-ffh
    logic [7:0] ram [32:255];

    // RAM write port; contents survive reset undefined
    always_ff @(posedge clk) begin
        if (wr_ram) ram[mem_addr] <= wr_data;
    end

    // TX queue
    logic [7:0] txq_tdata;
    logic       txq_tvalid;
    logic       txq_tready;
    logic       txq_pop;

    mem_bus_responder_txq #(.DEPTH(TXQ_DEPTH)) u_txq (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (wr_data),
        .s_tvalid (wr_txd),
        .s_tready (txq_tready),
        .m_tdata  (txq_tdata),
        .m_tvalid (txq_tvalid),
        .m_tready (txq_pop)
    );

    // TX serializer state
    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_bit_end;

    assign tx_bit_end = (tx_div_q == DIV_LAST);

    // TX state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // TX next state: pop in IDLE, then START/8xDATA/STOP each CLK_DIV clocks
    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txq_pop    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_div_d = '0;
                if (txq_tvalid) begin
                    txq_pop    = 1'b1;
                    tx_shift_d = txq_tdata;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_div_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_div_d = tx_div_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_div_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end else begin
                    tx_div_d = tx_div_q + 16'd1;
                end
            end
            default: begin
                if (tx_bit_end) begin
                    tx_div_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_div_d = tx_div_q + 16'd1;
                end
            end
        endcase
    end

    // line level follows the registered state, so reset forces it high at once
    assign uart_tx = (tx_state_q == TX_START) ? 1'b0 :
                     (tx_state_q == TX_DATA)  ? tx_shift_q[0] : 1'b1;

    // RX input synchronizer plus one delayed copy for edge detection
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    // two-flop synchronizer, idles high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_frame_ok;

    // RX state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX next state: start checked mid-bit, data and stop sampled a full bit apart
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_div_d    = rx_div_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_frame_ok = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_div_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_div_q == HALF_LAST) begin
                    rx_div_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_div_d = rx_div_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_div_q == DIV_LAST) begin
                    rx_div_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_div_d = rx_div_q + 16'd1;
                end
            end
            default: begin
                if (rx_div_q == DIV_LAST) begin
                    rx_div_d    = '0;
                    rx_state_d  = RX_IDLE;
                    rx_frame_ok = rx_sync_q;
                end else begin
                    rx_div_d = rx_div_q + 16'd1;
                end
            end
        endcase
    end

    // flag update terms; a clear of rx_valid on the stop edge lets the new byte in
    logic       rx_valid_q, tx_ovf_q, rx_ovr_q;
    logic [7:0] rx_data_q;
    logic       clr_rx_valid, clr_tx_ovf, clr_rx_ovr;
    logic       rx_load, rx_ovr_set, tx_ovf_set;

    assign clr_rx_valid = wr_ctl && wr_data[0];
    assign clr_tx_ovf   = wr_ctl && wr_data[2];
    assign clr_rx_ovr   = wr_ctl && wr_data[3];
    assign rx_load      = rx_frame_ok && (!rx_valid_q || clr_rx_valid);
    assign rx_ovr_set   = rx_frame_ok && rx_valid_q && !clr_rx_valid;
    assign tx_ovf_set   = wr_txd && !txq_tready;

    // status flags and RX holding register; sets win over clears
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid_q <= 1'b0;
            tx_ovf_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            if (rx_load)           rx_valid_q <= 1'b1;
            else if (clr_rx_valid) rx_valid_q <= 1'b0;
            if (rx_load) rx_data_q <= rx_shift_q;
            if (tx_ovf_set)        tx_ovf_q <= 1'b1;
            else if (clr_tx_ovf)   tx_ovf_q <= 1'b0;
            if (rx_ovr_set)        rx_ovr_q <= 1'b1;
            else if (clr_rx_ovr)   rx_ovr_q <= 1'b0;
        end
    end

    logic       tx_busy;
    logic [7:0] status;
    logic [7:0] rd_next;

    assign tx_busy = txq_tvalid || (tx_state_q != TX_IDLE);
    assign status  = {3'b000, tx_busy, rx_ovr_q, tx_ovf_q, !txq_tready, rx_valid_q};

    // read mux; nothing here has side effects
    always_comb begin
        rd_next = 8'h00;
        case (mem_addr)
            8'h00:   rd_next = 8'h00;
            8'h01:   rd_next = rx_data_q;
            8'h02:   rd_next = status;
            default: rd_next = sel_ram ? ram[mem_addr] : 8'h00;
        endcase
    end

    // registered read data, one clock after the address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data <= 8'h00;
        else      rd_data <= rd_next;
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - scoreboard bench for mem_bus_responder with behavioural bus/UART model
module tb_mem_bus_responder;
    localparam int D = 4;
    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] mem_addr = 8'h00;
    logic       mem_wr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       uart_rx = 1'b1;
    logic       uart_tx;

    always #5 clk = ~clk;

    mem_bus_responder #(.CLK_DIV(D), .TXQ_DEPTH(Q)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: bytes, flags, queue occupancy and serializer busy window
    logic [7:0] ram_m [256];
    bit         known [256];
    logic [7:0] known_list [$];
    int         cnt_m, now, active_end;
    bit         tx_ovf_m, rx_valid_m, rx_ovr_m, rx_known;
    logic [7:0] rx_data_m;
    logic [7:0] tx_exp [$];

    logic [7:0] rd_exp_q [$];
    string      rd_tag_q [$];
    logic       rd_chk = 1'b0;

    function automatic logic [7:0] status_m();
        bit busy;
        busy = (cnt_m > 0) || (now < active_end);
        return {3'b000, busy, rx_ovr_m, tx_ovf_m, cnt_m == Q, rx_valid_m};
    endfunction

    task automatic model_reset();
        cnt_m = 0; now = -1; active_end = -1;
        tx_ovf_m = 0; rx_valid_m = 0; rx_ovr_m = 0; rx_known = 0;
        for (int i = 0; i < 256; i++) known[i] = 0;
        known_list.delete();
        tx_exp.delete();
    endtask

    // one clock: apply the bus transaction to the model, then advance the DUT
    task automatic step();
        int e;
        bit pop, full_b;
        if (rst) begin
            e = now + 1;
            full_b = (cnt_m == Q);
            pop = (cnt_m > 0) && (e > active_end);
            if (mem_wr) begin
                if (mem_addr >= 8'h20) begin
                    if (!known[mem_addr]) known_list.push_back(mem_addr);
                    ram_m[mem_addr] = wr_data;
                    known[mem_addr] = 1;
                end else if (mem_addr == 8'h01) begin
                    if (full_b) tx_ovf_m = 1;
                    else begin
                        tx_exp.push_back(wr_data);
                        cnt_m++;
                    end
                end else if (mem_addr == 8'h02) begin
                    if (wr_data[0]) rx_valid_m = 0;
                    if (wr_data[2]) tx_ovf_m = 0;
                    if (wr_data[3]) rx_ovr_m = 0;
                end
            end
            if (pop) begin
                cnt_m--;
                active_end = e + 10 * D;
            end
            now = e;
        end
        @(posedge clk);
        #1;
        mem_wr = 1'b0;
        rd_chk = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        mem_addr = a; wr_data = d; mem_wr = 1'b1;
        step();
    endtask

    task automatic rd(input logic [7:0] a, input string nm);
        logic [7:0] exp;
        if (a == 8'h01)      exp = rx_data_m;
        else if (a == 8'h02) exp = status_m();
        else if (a >= 8'h20) exp = ram_m[a];
        else                 exp = 8'h00;
        rd_exp_q.push_back(exp);
        rd_tag_q.push_back(nm);
        mem_addr = a;
        rd_chk = 1'b1;
        step();
    endtask

    // drive one 8N1 frame on uart_rx, then fold its effect into the model
    task automatic send_rx(input logic [7:0] d, input bit stop);
        uart_rx = 1'b0;
        repeat (D) step();
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (D) step();
        end
        uart_rx = stop;
        repeat (D) step();
        uart_rx = 1'b1;
        repeat (2 * D) step();
        if (stop) begin
            if (rx_valid_m) rx_ovr_m = 1;
            else begin
                rx_data_m = d; rx_valid_m = 1; rx_known = 1;
            end
        end
    endtask

    task automatic wait_tx_idle(input string nm);
        int budget;
        budget = 0;
        while (((cnt_m > 0) || (now < active_end) || (tx_exp.size() != 0)) && budget < 2000) begin
            step();
            budget++;
        end
        repeat (2) step();
        chk({nm, "_drained"}, tx_exp.size(), 0);
    endtask

    // read-data monitor: compares rd_data one clock after each issued read
    initial begin
        logic [7:0] exp;
        string nm;
        forever begin
            @(posedge clk);
            if (rd_chk) begin
                @(negedge clk);
                if (rd_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_underflow: got read with no expectation");
                end else begin
                    exp = rd_exp_q.pop_front();
                    nm = rd_tag_q.pop_front();
                    chk(nm, rd_data, exp);
                end
            end
        end
    end

    // serial monitor: decodes frames on uart_tx mid-bit and matches the expected byte stream
    initial begin
        logic prev, aborted, start_b, stop_b;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b1;
            end else if (prev && !uart_tx) begin
                aborted = 0;
                for (int k = 0; k < D / 2 - 1; k++) begin
                    @(negedge clk); if (!rst) aborted = 1;
                end
                start_b = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    for (int k = 0; k < D; k++) begin
                        @(negedge clk); if (!rst) aborted = 1;
                    end
                    b[i] = uart_tx;
                end
                for (int k = 0; k < D; k++) begin
                    @(negedge clk); if (!rst) aborted = 1;
                end
                stop_b = uart_tx;
                if (!aborted) begin
                    chk("tx_start_bit", start_b, 1'b0);
                    chk("tx_stop_bit", stop_b, 1'b1);
                    if (tx_exp.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL tx_unexpected_frame: got %02h expected none", b);
                    end else begin
                        chk("tx_frame_byte", b, tx_exp.pop_front());
                    end
                end
                prev = uart_tx;
            end else begin
                prev = uart_tx;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int kind;
        logic [7:0] a;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_uart_tx", uart_tx, 1'b1);
        rst = 1'b1;

        rd(8'h00, "rd_null");
        rd(8'h02, "rd_status_reset");
        rd(8'h10, "rd_gap");

        wr(8'h20, 8'hA5);
        wr(8'hFF, 8'h3C);
        rd(8'h20, "rd_ram_20");
        rd(8'hFF, "rd_ram_ff");
        wr(8'h10, 8'h77);
        rd(8'h10, "rd_gap_after_write");
        wr(8'h40, 8'h12);
        rd(8'h40, "rd_after_write");

        wr(8'h01, 8'h55);
        repeat (5) step();
        rd(8'h02, "status_tx_busy");
        wait_tx_idle("tx_55");
        rd(8'h02, "status_tx_idle");

        wr(8'h01, 8'h11); wr(8'h01, 8'h22); wr(8'h01, 8'h33);
        wr(8'h01, 8'h44); wr(8'h01, 8'h55); wr(8'h01, 8'h66);
        rd(8'h02, "status_tx_ovf_full");
        wait_tx_idle("tx_burst");
        rd(8'h02, "status_ovf_held");
        wr(8'h02, 8'h04);
        rd(8'h02, "status_ovf_cleared");

        send_rx(8'hC3, 1'b1);
        rd(8'h02, "status_rx_valid");
        rd(8'h01, "rx_data_c3");
        send_rx(8'h5A, 1'b1);
        rd(8'h02, "status_rx_ovr");
        rd(8'h01, "rx_data_kept");
        wr(8'h02, 8'h09);
        rd(8'h02, "status_rx_cleared");

        uart_rx = 1'b0;
        repeat (2) step();
        uart_rx = 1'b1;
        repeat (3 * D) step();
        rd(8'h02, "status_after_glitch");
        send_rx(8'hA7, 1'b0);
        rd(8'h02, "status_after_frame_err");
        send_rx(8'h96, 1'b1);
        rd(8'h01, "rx_data_96");

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1: wr(8'(($urandom_range(32, 255))), 8'($urandom));
                2, 3: begin
                    if (known_list.size() != 0) begin
                        a = known_list[$urandom_range(0, known_list.size() - 1)];
                        rd(a, "rnd_ram");
                    end else rd(8'h00, "rnd_null");
                end
                4: begin
                    a = 8'($urandom_range(3, 31));
                    wr(a, 8'($urandom));
                    rd(a, "rnd_gap");
                end
                5, 6: rd(8'h02, "rnd_status");
                7: if ($urandom_range(0, 3) == 0) wr(8'h01, 8'($urandom)); else step();
                8: wr(8'h02, 8'($urandom));
                default: if (rx_known) rd(8'h01, "rnd_rx_data"); else step();
            endcase
        end
        wait_tx_idle("tx_random");
        rd(8'h02, "status_random_end");

        wr(8'h01, 8'hE1);
        wr(8'h01, 8'hE2);
        repeat (15) step();
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_uart_tx", uart_tx, 1'b1);
        chk("async_reset_rd_data", rd_data, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rd(8'h02, "status_after_reset");
        repeat (12 * D) step();
        chk("no_frame_after_reset", uart_tx, 1'b1);
        rd(8'h02, "status_still_idle");
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
